// File: rtl/padd_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
// Holds the op encoding, the chunk-width rule and the saturation constants.
// Saturation helpers return 64-bit patterns, so clamping supports WIDTH <= 64.
package padd_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Each pipeline stage owns one equal-width slice of the carry chain.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Largest positive two's-complement value for a given width.
  function automatic logic [63:0] sat_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value for a given width.
  function automatic logic [63:0] sat_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// One slice of the carry chain: C-bit ripple adder with carry in and out.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage register decides when it is sampled.
module add_chunk
  import padd_pkg::*;
#(
  parameter int C = 8
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit add/subtract; one carry chunk per stage, flags on the last stage.
// Latency: STAGES cycles from accept to out_valid; one result per cycle when unstalled.
// Backpressure: elastic per-stage valid bits; bubbles collapse; PADD_SAT_EN adds clamping.
module pipelined_add_sub
  import padd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int C = chunk_width(WIDTH, STAGES);

`ifdef PADD_SAT_EN
  localparam logic [63:0]      SAT_POS_X = sat_pos(WIDTH);
  localparam logic [63:0]      SAT_NEG_X = sat_neg(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS   = SAT_POS_X[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SAT_NEG   = SAT_NEG_X[WIDTH-1:0];
`endif

  // Per-stage valid bits and load enables.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] ld;

  // Stage registers: operands travel along so upper chunks are still available,
  // r_q accumulates the finished lower result chunks.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             c_q [STAGES];
  logic             ovf_q;
  logic             zero_q;

  // Per-stage inputs (from ports or the previous register) and next values.
  logic [WIDTH-1:0] a_i  [STAGES];
  logic [WIDTH-1:0] b_i  [STAGES];
  logic [WIDTH-1:0] r_i  [STAGES];
  logic             c_i  [STAGES];
  logic             vin  [STAGES];
  logic [WIDTH-1:0] nx_r [STAGES];
  logic             nx_c [STAGES];
  logic             ovf_n;
  logic             zero_n;

  // Subtract is folded into an add of the inverted operand with inverted carry-in.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  assign b_eff = (sub == OP_ADD) ? b : ~b;
  assign c_eff = (sub == OP_SUB) ? ~cin : cin;

  // A stage may load when it is empty or every stage downstream of it can move.
  for (genvar k = 0; k < STAGES; k++) begin : g_ld
    assign ld[k] = out_ready || !(&v[STAGES-1:k]);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [C-1:0] s_chunk;
    logic         c_chunk;

    if (k == 0) begin : g_first
      assign a_i[k] = a;
      assign b_i[k] = b_eff;
      assign c_i[k] = c_eff;
      assign r_i[k] = '0;
      assign vin[k] = in_valid;
    end else begin : g_next
      assign a_i[k] = a_q[k-1];
      assign b_i[k] = b_q[k-1];
      assign c_i[k] = c_q[k-1];
      assign r_i[k] = r_q[k-1];
      assign vin[k] = v[k-1];
    end

    add_chunk #(.C(C)) u_chunk (
      .a    (a_i[k][k*C +: C]),
      .b    (b_i[k][k*C +: C]),
      .cin  (c_i[k]),
      .sum  (s_chunk),
      .cout (c_chunk)
    );

    assign nx_c[k] = c_chunk;

    if (k == STAGES - 1) begin : g_last
      logic [WIDTH-1:0] raw;
      logic             of;
      // Chunks above k are still zero in r_i, so OR places the new slice.
      assign raw = r_i[k] | (WIDTH'(s_chunk) << (k * C));
      assign of  = (a_i[k][WIDTH-1] == b_i[k][WIDTH-1]) && (raw[WIDTH-1] != a_i[k][WIDTH-1]);
`ifdef PADD_SAT_EN
      // Overflow direction follows the sign of a: positive a can only overflow upward.
      assign nx_r[k] = of ? (a_i[k][WIDTH-1] ? SAT_NEG : SAT_POS) : raw;
`else
      assign nx_r[k] = raw;
`endif
      assign ovf_n  = of;
      assign zero_n = (nx_r[k] == '0);
    end else begin : g_mid
      assign nx_r[k] = r_i[k] | (WIDTH'(s_chunk) << (k * C));
    end
  end

  // Stage registers: valid moves on every load, data only when the incoming slot is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v      <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= vin[k];
          if (vin[k]) begin
            a_q[k] <= a_i[k];
            b_q[k] <= b_i[k];
            r_q[k] <= nx_r[k];
            c_q[k] <= nx_c[k];
          end
        end
      end
      if (ld[STAGES-1] && vin[STAGES-1]) begin
        ovf_q  <= ovf_n;
        zero_q <= zero_n;
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v[STAGES-1];
  assign sum       = r_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub (WIDTH = 32, STAGES = 4).
// Covers reset, add/sub/borrow arithmetic, latency, backpressure, bubbles, mid-flight reset.
// Expected values for saturation follow PADD_SAT_EN when it is defined for the build.
module tb_pipelined_add_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int checks;
  int errors;

  pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation into an empty pipe and waits (bounded) for its result.
  task automatic run_single(input logic [31:0] ta, input logic [31:0] tb, input logic tcin,
                            input logic tsub, output logic [31:0] rs, output logic rc,
                            output logic ro, output logic rz, output int lat);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    cin       = tcin;
    sub       = tsub;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum;
    rc = cout;
    ro = ovf;
    rz = zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", cout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [31:0] rs; logic rc, ro, rz; int lat;
    run_single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, rz, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", lat); end
    checks++; if (rs !== 32'h0) begin errors++; $display("FAIL add_sum: got %h expected 00000000", rs); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL add_cout: got %b expected 1", rc); end
    checks++; if (rz !== 1'b1) begin errors++; $display("FAIL add_zero: got %b expected 1", rz); end
    checks++; if (ro !== 1'b0) begin errors++; $display("FAIL add_ovf: got %b expected 0", ro); end
    run_single(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, rs, rc, ro, rz, lat);
    checks++; if (rs !== 32'h2345_678A) begin errors++; $display("FAIL add_cin_sum: got %h expected 2345678a", rs); end
    checks++; if (rc !== 1'b0 || ro !== 1'b0) begin errors++; $display("FAIL add_cin_flags: got cout=%b ovf=%b expected 0 0", rc, ro); end
    run_single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, rs, rc, ro, rz, lat);
`ifdef PADD_SAT_EN
    checks++; if (rs !== 32'h7FFF_FFFF) begin errors++; $display("FAIL add_pos_ovf_sum: got %h expected 7fffffff", rs); end
`else
    checks++; if (rs !== 32'h8000_0000) begin errors++; $display("FAIL add_pos_ovf_sum: got %h expected 80000000", rs); end
`endif
    checks++; if (ro !== 1'b1 || rc !== 1'b0) begin errors++; $display("FAIL add_pos_ovf_flags: got ovf=%b cout=%b expected 1 0", ro, rc); end
  endtask

  task automatic test_sub();
    logic [31:0] rs; logic rc, ro, rz; int lat;
    run_single(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, rs, rc, ro, rz, lat);
`ifdef PADD_SAT_EN
    checks++; if (rs !== 32'h8000_0000) begin errors++; $display("FAIL sub_sum: got %h expected 80000000", rs); end
`else
    checks++; if (rs !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_sum: got %h expected 7fffffff", rs); end
`endif
    checks++; if (ro !== 1'b1) begin errors++; $display("FAIL sub_ovf: got %b expected 1", ro); end
    checks++; if (rc !== 1'b1) begin errors++; $display("FAIL sub_cout: got %b expected 1", rc); end
    checks++; if (rz !== 1'b0) begin errors++; $display("FAIL sub_zero: got %b expected 0", rz); end
  endtask

  task automatic test_borrow_in();
    logic [31:0] rs; logic rc, ro, rz; int lat;
    run_single(32'd5, 32'd5, 1'b1, 1'b1, rs, rc, ro, rz, lat);
    checks++; if (rs !== 32'hFFFF_FFFF) begin errors++; $display("FAIL borrow_sum: got %h expected ffffffff", rs); end
    checks++; if (rc !== 1'b0) begin errors++; $display("FAIL borrow_cout: got %b expected 0", rc); end
    checks++; if (rz !== 1'b0) begin errors++; $display("FAIL borrow_zero: got %b expected 0", rz); end
    checks++; if (ro !== 1'b0) begin errors++; $display("FAIL borrow_ovf: got %b expected 0", ro); end
    run_single(32'd9, 32'd9, 1'b0, 1'b1, rs, rc, ro, rz, lat);
    checks++; if (rs !== 32'h0 || rz !== 1'b1 || rc !== 1'b1) begin errors++; $display("FAIL sub_equal: got sum=%h zero=%b cout=%b expected 00000000 1 1", rs, rz, rc); end
  endtask

  // Eight back-to-back adds of i+i with the sink stalled for cycles 5..10.
  task automatic test_back_to_back();
    int src, expn, nlow;
    src = 1; expn = 1; nlow = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 5 && c <= 10);
      in_valid  = (src <= 8);
      a   = 32'(src);
      b   = 32'(src);
      cin = 1'b0;
      sub = 1'b0;
      @(negedge clk);
      if (!in_ready) nlow++;
      if (out_valid) begin
        checks++;
        if (sum !== 32'(2 * expn)) begin
          errors++;
          $display("FAIL stream_data cycle %0d: got %0d expected %0d", c, sum, 2 * expn);
        end
        if (out_ready) expn++;
      end
      if (in_valid && in_ready) src++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (expn !== 9) begin errors++; $display("FAIL stream_count: got %0d results expected 8", expn - 1); end
    checks++; if (src !== 9) begin errors++; $display("FAIL stream_accepts: got %0d accepts expected 8", src - 1); end
    checks++; if (nlow !== 6) begin errors++; $display("FAIL stream_in_ready_low: got %0d cycles expected 6", nlow); end
  endtask

  // Two ops separated by idle cycles while the sink is stalled.
  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd3; b = 32'd4; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b1; a = 32'd10; b = 32'd20;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_second_accept: got in_ready=%b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || sum !== 32'd7) begin errors++; $display("FAIL bubble_held_first: got valid=%b sum=%0d expected 1 7", out_valid, sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || sum !== 32'd7) begin errors++; $display("FAIL bubble_drain_first: got valid=%b sum=%0d expected 1 7", out_valid, sum); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || sum !== 32'd30) begin errors++; $display("FAIL bubble_drain_second: got valid=%b sum=%0d expected 1 30", out_valid, sum); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_empty: got valid=%b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

  // Three ops in flight, asynchronous reset pulse, then a fresh op.
  task automatic test_reset_mid();
    int stale;
    logic [31:0] rs; logic rc, ro, rz; int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'(100 + i); b = 32'd1; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #3;
    checks++; if (out_valid !== 1'b1 || sum !== 32'd101) begin errors++; $display("FAIL rstmid_pre: got valid=%b sum=%0d expected 1 101", out_valid, sum); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL rstmid_async_sum: got %h expected 00000000", sum); end
    #17;
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d valid cycles expected 0", stale); end
    run_single(32'd7, 32'd8, 1'b0, 1'b0, rs, rc, ro, rz, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_latency: got %0d expected 4", lat); end
    checks++; if (rs !== 32'd15) begin errors++; $display("FAIL rstmid_sum: got %0d expected 15", rs); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_borrow_in();
    test_back_to_back();
    test_bubble();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
